// File: rtl/gelato_fetch_pkg.sv
// gelato_fetch_pkg: shared warp/PC widths, types and FSM encoding for the warp fetch arbiter
package gelato_fetch_pkg;
    localparam int NUM_WARPS = 32;
    localparam int WARP_ID_W = $clog2(NUM_WARPS);
    localparam int PC_W      = 32;

    typedef logic [WARP_ID_W-1:0] warp_id_t;
    typedef logic [PC_W-1:0]      pc_t;
    typedef logic [NUM_WARPS-1:0] warp_mask_t;
    typedef enum logic {IDLE, REQ} fetch_state_t;

    function automatic warp_mask_t warp_onehot(input warp_id_t w);
        return warp_mask_t'(1) << w;
    endfunction
endpackage

// File: rtl/gelato_rr_arbiter.sv
// gelato_rr_arbiter: combinational round-robin pick, lowest index at or after start wins
module gelato_rr_arbiter #(
    parameter int N  = 32,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] start,
    output logic          gnt_valid,
    output logic [IW-1:0] gnt_idx
);
    logic [N-1:0]  rot;
    logic [IW-1:0] rot_idx;

    // N is a power of two, so adding start back wraps the index for free
    always_comb begin
        rot = N'({req, req} >> start);
        rot_idx = '0;
        for (int i = N - 1; i >= 0; i--)
            if (rot[i]) rot_idx = IW'(i);
        gnt_valid = |req;
        gnt_idx = rot_idx + start;
    end
endmodule

// File: rtl/gelato_warp_fetch_arbiter.sv
// gelato_warp_fetch_arbiter: round-robin warp selection for instruction fetch with an in-flight cap
module gelato_warp_fetch_arbiter
    import gelato_fetch_pkg::*;
#(
    parameter int MAX_INFLIGHT = 4,
    localparam int CNT_W = $clog2(MAX_INFLIGHT + 1)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      rdy,
    input  logic [NUM_WARPS-1:0]      warp_active,
    input  logic [NUM_WARPS*PC_W-1:0] warp_pc,
    input  logic [NUM_WARPS-1:0]      ibuf_full,
    output logic                      fetch_valid,
    input  logic                      fetch_ready,
    output logic [WARP_ID_W-1:0]      fetch_warp_id,
    output logic [PC_W-1:0]           fetch_pc,
    input  logic                      done_valid,
    input  logic [WARP_ID_W-1:0]      done_warp_id,
    output logic [CNT_W-1:0]          inflight_cnt,
    output logic                      err_spurious
);
    localparam int CW1 = CNT_W + 1;

    fetch_state_t     state_q, state_d;
    warp_id_t         id_q, id_d, rr_q, rr_d, start, gnt_idx;
    pc_t              pc_q, pc_d;
    warp_mask_t       pend_q, pend_d, eligible;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W:0]   cnt_after;
    logic             err_q, err_d, hs, done_hit, pick_ok, gnt_valid;

    gelato_rr_arbiter #(.N(NUM_WARPS)) u_rr (
        .req      (eligible),
        .start    (start),
        .gnt_valid(gnt_valid),
        .gnt_idx  (gnt_idx)
    );

    // cnt_after counts the request being accepted this cycle; a new pick needs one more slot beyond it
    always_comb begin
        hs = state_q == REQ && fetch_ready;
        eligible = warp_active & ~ibuf_full & ~pend_q & ~(state_q == REQ ? warp_onehot(id_q) : '0);
        start = hs ? id_q + 1'b1 : rr_q;
        done_hit = done_valid && pend_q[done_warp_id];
        cnt_after = {1'b0, cnt_q} + CW1'(hs);
        pick_ok = (state_q == IDLE || hs) && gnt_valid && cnt_after < CW1'(MAX_INFLIGHT);
        state_d = pick_ok ? REQ : (hs ? IDLE : state_q);
        id_d = pick_ok ? gnt_idx : id_q;
        pc_d = pick_ok ? warp_pc[gnt_idx*PC_W +: PC_W] : pc_q;
        rr_d = hs ? start : rr_q;
        pend_d = (pend_q | (hs ? warp_onehot(id_q) : '0)) & ~(done_hit ? warp_onehot(done_warp_id) : '0);
        cnt_d = CNT_W'(cnt_after - CW1'(done_hit));
        err_d = err_q | (done_valid && !done_hit);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            id_q <= '0;
            pc_q <= '0;
            rr_q <= '0;
            pend_q <= '0;
            cnt_q <= '0;
            err_q <= 1'b0;
        end else if (rdy) begin
            state_q <= state_d;
            id_q <= id_d;
            pc_q <= pc_d;
            rr_q <= rr_d;
            pend_q <= pend_d;
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign fetch_valid = state_q == REQ;
    assign fetch_warp_id = id_q;
    assign fetch_pc = pc_q;
    assign inflight_cnt = cnt_q;
    assign err_spurious = err_q;
endmodule

// File: tb/tb_gelato_warp_fetch_arbiter.sv
// tb_gelato_warp_fetch_arbiter: scoreboard bench, expected grants queued with stimulus and popped on handshake
module tb_gelato_warp_fetch_arbiter;
    import gelato_fetch_pkg::*;

    logic                      clk = 1'b0;
    logic                      rst_n = 1'b0;
    logic                      rdy = 1'b1;
    logic [NUM_WARPS-1:0]      warp_active = '0;
    logic [NUM_WARPS*PC_W-1:0] warp_pc = '0;
    logic [NUM_WARPS-1:0]      ibuf_full = '0;
    logic                      fetch_valid;
    logic                      fetch_ready = 1'b0;
    logic [WARP_ID_W-1:0]      fetch_warp_id;
    logic [PC_W-1:0]           fetch_pc;
    logic                      done_valid = 1'b0;
    logic [WARP_ID_W-1:0]      done_warp_id = '0;
    logic [2:0]                inflight_cnt;
    logic                      err_spurious;

    typedef struct packed {warp_id_t id; pc_t pc;} grant_t;
    grant_t exp_q[$];
    grant_t mon_g;
    int checks = 0;
    int failures = 0;

    gelato_warp_fetch_arbiter #(.MAX_INFLIGHT(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rdy          (rdy),
        .warp_active  (warp_active),
        .warp_pc      (warp_pc),
        .ibuf_full    (ibuf_full),
        .fetch_valid  (fetch_valid),
        .fetch_ready  (fetch_ready),
        .fetch_warp_id(fetch_warp_id),
        .fetch_pc     (fetch_pc),
        .done_valid   (done_valid),
        .done_warp_id (done_warp_id),
        .inflight_cnt (inflight_cnt),
        .err_spurious (err_spurious)
    );

    always #5 clk = ~clk;

    function automatic pc_t pc_of(input int w);
        return pc_t'(32'h0040_0000 + w * 16);
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_grant(input int w);
        grant_t g;
        g.id = warp_id_t'(w);
        g.pc = pc_of(w);
        exp_q.push_back(g);
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        rdy = 1'b1;
        fetch_ready = 1'b0;
        done_valid = 1'b0;
        warp_active = '0;
        ibuf_full = '0;
        for (int w = 0; w < NUM_WARPS; w++) warp_pc[w*PC_W +: PC_W] = pc_of(w);
        step();
        step();
    endtask

    task automatic chk_req(input string tag, input logic v, input int w, input int cnt);
        chk({tag, "_valid"}, 64'(fetch_valid), 64'(v));
        if (v) chk({tag, "_id"}, 64'(fetch_warp_id), 64'(w));
        chk({tag, "_cnt"}, 64'(inflight_cnt), 64'(cnt));
    endtask

    // a handshake is decided at the next rising edge; inputs are stable by the falling edge
    always @(negedge clk) begin
        if (rst_n && rdy && fetch_valid && fetch_ready) begin
            if (exp_q.size() == 0) chk("grant_extra", 64'(fetch_warp_id), 64'hFFFF);
            else begin
                mon_g = exp_q.pop_front();
                chk("grant_id", 64'(fetch_warp_id), 64'(mon_g.id));
                chk("grant_pc", 64'(fetch_pc), 64'(mon_g.pc));
            end
        end
    end

    initial begin
        reset_dut();
        chk("rst_valid", 64'(fetch_valid), 64'd0);
        chk("rst_id", 64'(fetch_warp_id), 64'd0);
        chk("rst_pc", 64'(fetch_pc), 64'd0);
        chk("rst_cnt", 64'(inflight_cnt), 64'd0);
        chk("rst_err", 64'(err_spurious), 64'd0);

        warp_active = 32'h0000_0029;
        fetch_ready = 1'b1;
        expect_grant(0);
        expect_grant(3);
        expect_grant(5);
        rst_n = 1'b1;
        step();
        chk_req("t1_c1", 1'b1, 0, 0);
        step();
        chk_req("t1_c2", 1'b1, 3, 1);
        step();
        chk_req("t1_c3", 1'b1, 5, 2);
        step();
        chk_req("t1_end", 1'b0, 0, 3);
        chk("t1_left", 64'(exp_q.size()), 64'd0);

        reset_dut();
        warp_active = 32'h0000_00FF;
        fetch_ready = 1'b1;
        for (int w = 0; w < 4; w++) expect_grant(w);
        rst_n = 1'b1;
        repeat (5) step();
        chk_req("t2_cap", 1'b0, 0, 4);
        repeat (2) step();
        chk_req("t2_cap_hold", 1'b0, 0, 4);
        expect_grant(4);
        done_valid = 1'b1;
        done_warp_id = 5'd1;
        step();
        done_valid = 1'b0;
        chk("t2_done_cnt", 64'(inflight_cnt), 64'd3);
        step();
        chk_req("t2_rr", 1'b1, 4, 3);
        step();
        chk_req("t2_recap", 1'b0, 0, 4);
        chk("t2_left", 64'(exp_q.size()), 64'd0);

        reset_dut();
        warp_active = 32'h0000_0004;
        expect_grant(2);
        rst_n = 1'b1;
        step();
        chk_req("t3_req", 1'b1, 2, 0);
        for (int i = 0; i < 5; i++) begin
            if (i == 1) begin
                warp_pc[2*PC_W +: PC_W] = 32'hDEAD_BEEF;
                ibuf_full[2] = 1'b1;
            end
            step();
            chk("t3_hold_id", 64'(fetch_warp_id), 64'd2);
            chk("t3_hold_pc", 64'(fetch_pc), 64'(pc_of(2)));
        end
        fetch_ready = 1'b1;
        step();
        chk_req("t3_after", 1'b0, 0, 1);
        chk("t3_left", 64'(exp_q.size()), 64'd0);

        reset_dut();
        warp_active = 32'h0000_0003;
        fetch_ready = 1'b1;
        expect_grant(0);
        expect_grant(1);
        rst_n = 1'b1;
        step();
        step();
        chk_req("t4_req1", 1'b1, 1, 1);
        done_valid = 1'b1;
        done_warp_id = 5'd0;
        expect_grant(0);
        step();
        done_valid = 1'b0;
        chk_req("t4_hs_done", 1'b0, 0, 1);
        step();
        chk_req("t4_reelig", 1'b1, 0, 1);
        step();
        chk_req("t4_end", 1'b0, 0, 2);
        chk("t4_left", 64'(exp_q.size()), 64'd0);

        chk("t5_err_pre", 64'(err_spurious), 64'd0);
        done_valid = 1'b1;
        done_warp_id = 5'd6;
        step();
        done_valid = 1'b0;
        chk("t5_err", 64'(err_spurious), 64'd1);
        chk("t5_cnt", 64'(inflight_cnt), 64'd2);
        repeat (2) step();
        chk("t5_err_sticky", 64'(err_spurious), 64'd1);

        reset_dut();
        warp_active = 32'h0000_00FF;
        fetch_ready = 1'b1;
        for (int w = 0; w < 3; w++) expect_grant(w);
        rst_n = 1'b1;
        repeat (4) step();
        fetch_ready = 1'b0;
        chk_req("t6_full", 1'b1, 3, 3);
        done_valid = 1'b1;
        done_warp_id = 5'd20;
        step();
        done_valid = 1'b0;
        chk("t6_err", 64'(err_spurious), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_arst_valid", 64'(fetch_valid), 64'd0);
        chk("t6_arst_id", 64'(fetch_warp_id), 64'd0);
        chk("t6_arst_pc", 64'(fetch_pc), 64'd0);
        chk("t6_arst_cnt", 64'(inflight_cnt), 64'd0);
        chk("t6_arst_err", 64'(err_spurious), 64'd0);
        step();
        fetch_ready = 1'b1;
        expect_grant(0);
        expect_grant(1);
        rst_n = 1'b1;
        step();
        step();
        rdy = 1'b0;
        done_valid = 1'b1;
        done_warp_id = 5'd0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_req("t6_freeze", 1'b1, 1, 1);
        end
        rdy = 1'b1;
        done_valid = 1'b0;
        step();
        fetch_ready = 1'b0;
        chk_req("t6_resume", 1'b1, 2, 2);
        chk("t6_left", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
